// File: rtl/dac_update_scheduler.sv
// dac_update_scheduler
//   Owns the single DAC channel. Two requesters, the SPGD engine and the host
//   register path, share it through a round-robin arbiter. The arbiter favours
//   the host out of reset. Each accepted code is optionally converted from
//   offset binary to two's complement and registered onto dac_data. A
//   programmable settle interval then runs, and settle_done pulses when it
//   ends.
//
// Ports
//   clk, rst                    clock; asynchronous active-high reset
//   spgd_valid/ready/code       SPGD requester (ready is combinational, IDLE only)
//   host_valid/ready/code       host requester (ready is combinational, IDLE only)
//   fmt_offset_bin              1 = convert offset binary, 0 = pass through
//   dac_data, dac_we            registered DAC code and its one-cycle write strobe
//   busy                        high from acceptance until the settle interval ends
//   settle_done                 one-cycle pulse in the final settle cycle
//   last_src                    source of the current dac_data (0 = SPGD, 1 = host)
//
// Optional feature (macro DAC_SCHED_CLAMP_EN)
//   Adds the clamp_min and clamp_max inputs and the sticky clamp_hit output.
//   Each accepted code is saturated to [clamp_min, clamp_max], compared as an
//   unsigned value, before conversion. If clamp_min > clamp_max, the code is
//   forced to clamp_min.

module dac_update_scheduler #(
  parameter int unsigned WIRE_WIDTH    = 14,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spgd_valid,
  output logic                  spgd_ready,
  input  logic [WIRE_WIDTH-1:0] spgd_code,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic [WIRE_WIDTH-1:0] host_code,
  input  logic                  fmt_offset_bin,
`ifdef DAC_SCHED_CLAMP_EN
  input  logic [WIRE_WIDTH-1:0] clamp_min,
  input  logic [WIRE_WIDTH-1:0] clamp_max,
  output logic                  clamp_hit,
`endif
  output logic [WIRE_WIDTH-1:0] dac_data,
  output logic                  dac_we,
  output logic                  busy,
  output logic                  settle_done,
  output logic                  last_src
);

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE} state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(SETTLE_CYCLES - 1);

  state_e                state_q;
  logic                  rr_host_q;   // 1 = host wins a tie
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [WIRE_WIDTH-1:0] dac_data_q;
  logic                  dac_we_q;
  logic                  busy_q;
  logic                  settle_done_q;
  logic                  last_src_q;

  logic                  grant_host;
  logic                  grant_spgd;
  logic                  accept;
  logic [WIRE_WIDTH-1:0] code_sel;
  logic [WIRE_WIDTH-1:0] code_lim;
  logic [WIRE_WIDTH-1:0] code_conv;

  always_comb begin
    grant_host = 1'b0;
    grant_spgd = 1'b0;
    if (state_q == IDLE) begin
      if (host_valid && (!spgd_valid || rr_host_q)) grant_host = 1'b1;
      else if (spgd_valid)                          grant_spgd = 1'b1;
    end
  end

  assign host_ready = grant_host;
  assign spgd_ready = grant_spgd;
  assign accept     = grant_host | grant_spgd;
  assign code_sel   = grant_host ? host_code : spgd_code;

`ifdef DAC_SCHED_CLAMP_EN
  logic clamp_now;
  logic clamp_hit_q;

  always_comb begin
    code_lim = code_sel;
    if (clamp_min > clamp_max)      code_lim = clamp_min;
    else if (code_sel < clamp_min)  code_lim = clamp_min;
    else if (code_sel > clamp_max)  code_lim = clamp_max;
    clamp_now = (code_lim != code_sel);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     clamp_hit_q <= 1'b0;
    else if (accept & clamp_now) clamp_hit_q <= 1'b1;
  end

  assign clamp_hit = clamp_hit_q;
`else
  assign code_lim = code_sel;
`endif

  // Offset binary to two's complement: flip the MSB.
  assign code_conv = fmt_offset_bin
                   ? {~code_lim[WIRE_WIDTH-1], code_lim[WIRE_WIDTH-2:0]}
                   : code_lim;

  // The output registers load on the accept edge, so the new dac_data,
  // dac_we and last_src are visible throughout the LOAD cycle. LOAD itself
  // arms the settle counter. settle_done is raised one edge early so that
  // it is high during the final SETTLE cycle, the cycle that returns to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_host_q     <= 1'b1;
      cnt_q         <= '0;
      dac_data_q    <= '0;
      dac_we_q      <= 1'b0;
      busy_q        <= 1'b0;
      settle_done_q <= 1'b0;
      last_src_q    <= 1'b0;
    end else begin
      dac_we_q      <= 1'b0;
      settle_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            dac_data_q <= code_conv;
            dac_we_q   <= 1'b1;
            last_src_q <= grant_host;
            rr_host_q  <= grant_spgd;
            busy_q     <= 1'b1;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          cnt_q   <= CNT_LOAD;
          state_q <= SETTLE;
          if (CNT_LOAD == '0) settle_done_q <= 1'b1;
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_WIDTH'(1);
            if (cnt_q == CNT_WIDTH'(1)) settle_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dac_data    = dac_data_q;
  assign dac_we      = dac_we_q;
  assign busy        = busy_q;
  assign settle_done = settle_done_q;
  assign last_src    = last_src_q;

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Directed testbench for dac_update_scheduler (SETTLE_CYCLES = 16).
// Inputs are driven just after each falling edge. Outputs are sampled 1 ns
// later, so every sample lies between rising edges.
module tb_dac_update_scheduler;
  localparam int W = 14;

  logic         clk;
  logic         rst;
  logic         spgd_valid, spgd_ready, host_valid, host_ready;
  logic [W-1:0] spgd_code, host_code, dac_data;
  logic         fmt_offset_bin, dac_we, busy, settle_done, last_src;
`ifdef DAC_SCHED_CLAMP_EN
  logic [W-1:0] clamp_min, clamp_max;
  logic         clamp_hit;
`endif

  int tests = 0;
  int fails = 0;

  dac_update_scheduler #(
    .WIRE_WIDTH(W), .SETTLE_CYCLES(16), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .spgd_valid(spgd_valid), .spgd_ready(spgd_ready), .spgd_code(spgd_code),
    .host_valid(host_valid), .host_ready(host_ready), .host_code(host_code),
    .fmt_offset_bin(fmt_offset_bin),
`ifdef DAC_SCHED_CLAMP_EN
    .clamp_min(clamp_min), .clamp_max(clamp_max), .clamp_hit(clamp_hit),
`endif
    .dac_data(dac_data), .dac_we(dac_we), .busy(busy),
    .settle_done(settle_done), .last_src(last_src)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  int       bad, first, nd, nwe, na, nw, both, host_acc, nhr, we_i;
  logic     b17, b18;
  int       acc_i   [3];
  logic     acc_src [3];
  logic [W-1:0] we_data [3];

  initial begin
    rst = 1'b1; spgd_valid = 1'b0; host_valid = 1'b0;
    spgd_code = '0; host_code = '0; fmt_offset_bin = 1'b0;
`ifdef DAC_SCHED_CLAMP_EN
    clamp_min = '0; clamp_max = 14'h3FFF;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chkw("rst_dac_data", dac_data, 14'h0000);
    chk1("rst_dac_we", dac_we, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_settle_done", settle_done, 1'b0);
    chk1("rst_last_src", last_src, 1'b0);
    @(negedge clk); rst = 1'b0;

    // Idle for 50 cycles: nothing may move
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (dac_we || busy || spgd_ready || host_ready || settle_done) bad++;
    end
    chki("idle_activity", bad, 0);
    chkw("idle_dac_data", dac_data, 14'h0000);

    // Single SPGD update 0x3FFF offset binary -> 0x1FFF
    @(negedge clk);
    spgd_code = 14'h3FFF; fmt_offset_bin = 1'b1; spgd_valid = 1'b1; #1;
    chk1("t2_spgd_ready", spgd_ready, 1'b1);
    chk1("t2_host_ready", host_ready, 1'b0);
    @(negedge clk); spgd_valid = 1'b0; spgd_code = '0; #1;
    chkw("t2_dac_data", dac_data, 14'h1FFF);
    chk1("t2_dac_we", dac_we, 1'b1);
    chk1("t2_last_src", last_src, 1'b0);
    chk1("t2_busy", busy, 1'b1);
    first = -1; nd = 0; nwe = 0; b17 = 1'b0; b18 = 1'b1;
    for (int i = 2; i <= 20; i++) begin
      @(negedge clk); #1;
      if (settle_done) begin nd++; if (first < 0) first = i; end
      if (dac_we) nwe++;
      if (i == 17) b17 = busy;
      if (i == 18) b18 = busy;
    end
    chki("t2_settle_cycle", first, 17);
    chki("t2_settle_pulses", nd, 1);
    chki("t2_extra_we", nwe, 0);
    chk1("t2_busy_last_settle", b17, 1'b1);
    chk1("t2_busy_after", b18, 1'b0);

    // Both requesters held: host, SPGD, host, 18 cycles apart
    na = 0; nw = 0; both = 0;
    for (int k = 0; k < 3; k++) begin acc_i[k] = -1; acc_src[k] = 1'bx; we_data[k] = 'x; end
    for (int i = 0; i <= 54; i++) begin
      @(negedge clk);
      if (i == 0) begin
        host_code = 14'h0100; spgd_code = 14'h0200; fmt_offset_bin = 1'b0;
        host_valid = 1'b1; spgd_valid = 1'b1;
      end
      if (i == 37) begin host_valid = 1'b0; spgd_valid = 1'b0; end
      #1;
      if (host_ready && spgd_ready) both++;
      if (host_ready || spgd_ready) begin
        if (na < 3) begin acc_i[na] = i; acc_src[na] = host_ready; end
        na++;
      end
      if (dac_we) begin
        if (nw < 3) we_data[nw] = dac_data;
        nw++;
      end
    end
    chki("t3_accepts", na, 3);
    chki("t3_both_ready", both, 0);
    chki("t3_acc0_cycle", acc_i[0], 0);
    chki("t3_acc1_cycle", acc_i[1], 18);
    chki("t3_acc2_cycle", acc_i[2], 36);
    chk1("t3_acc0_host", acc_src[0], 1'b1);
    chk1("t3_acc1_host", acc_src[1], 1'b0);
    chk1("t3_acc2_host", acc_src[2], 1'b1);
    chki("t3_writes", nw, 3);
    chkw("t3_data0", we_data[0], 14'h0100);
    chkw("t3_data1", we_data[1], 14'h0200);
    chkw("t3_data2", we_data[2], 14'h0100);

    // SPGD 0x2000 -> 0x0000, then a host request raised during SETTLE
    @(negedge clk);
    spgd_code = 14'h2000; fmt_offset_bin = 1'b1; spgd_valid = 1'b1; #1;
    chk1("t4_spgd_ready", spgd_ready, 1'b1);
    @(negedge clk); spgd_valid = 1'b0; #1;
    chkw("t4_dac_data", dac_data, 14'h0000);
    chk1("t4_dac_we", dac_we, 1'b1);
    first = -1; host_acc = -1; nhr = 0; nwe = 0; we_i = -1;
    for (int i = 2; i <= 23; i++) begin
      @(negedge clk);
      if (i == 2) begin host_code = 14'h0123; host_valid = 1'b1; end
      if (host_acc >= 0 && i == host_acc + 1) host_valid = 1'b0;
      #1;
      if (host_ready) begin nhr++; if (host_acc < 0) host_acc = i; end
      if (settle_done && first < 0) first = i;
      if (dac_we) begin nwe++; we_i = i; end
    end
    chki("t4_settle_cycle", first, 17);
    chki("t4_host_accept", host_acc, 18);
    chki("t4_host_ready_cnt", nhr, 1);
    chki("t4_we_count", nwe, 1);
    chki("t4_we_cycle", we_i, 19);
    chkw("t4_host_data", dac_data, 14'h2123);
    chk1("t4_last_src", last_src, 1'b1);

    // Reset 5 cycles after the host dac_we (i = 24), inside SETTLE
    @(negedge clk); rst = 1'b1; #1;
    chkw("t5_rst_dac_data", dac_data, 14'h0000);
    chk1("t5_rst_busy", busy, 1'b0);
    chk1("t5_rst_last_src", last_src, 1'b0);
    chk1("t5_rst_settle_done", settle_done, 1'b0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    bad = 0;
    for (int i = 27; i <= 40; i++) begin
      @(negedge clk); #1;
      if (settle_done || busy || dac_we) bad++;
    end
    chki("t5_no_stale_settle", bad, 0);

    // Fresh tie after reset: host wins; 0x0000 offset binary -> 0x2000
    @(negedge clk);
    host_code = 14'h0000; spgd_code = 14'h1111; fmt_offset_bin = 1'b1;
    host_valid = 1'b1; spgd_valid = 1'b1; #1;
    chk1("t5_host_ready", host_ready, 1'b1);
    chk1("t5_spgd_ready", spgd_ready, 1'b0);
    @(negedge clk); host_valid = 1'b0; spgd_valid = 1'b0; #1;
    chkw("t5_dac_data", dac_data, 14'h2000);
    chk1("t5_last_src", last_src, 1'b1);
    chk1("t5_dac_we", dac_we, 1'b1);
    first = -1; nd = 0;
    for (int i = 2; i <= 20; i++) begin
      @(negedge clk);
      if (i == 6) fmt_offset_bin = 1'b0;
      #1;
      if (settle_done) begin nd++; if (first < 0) first = i; end
    end
    chki("t5_settle_cycle", first, 17);
    chki("t5_settle_pulses", nd, 1);
    chkw("t5_fmt_change_hold", dac_data, 14'h2000);

`ifdef DAC_SCHED_CLAMP_EN
    chk1("cl_hit_initial", clamp_hit, 1'b0);
    clamp_min = 14'h1000; clamp_max = 14'h3000;
    @(negedge clk);
    spgd_code = 14'h3FF0; fmt_offset_bin = 1'b1; spgd_valid = 1'b1; #1;
    chk1("cl_spgd_ready", spgd_ready, 1'b1);
    @(negedge clk); spgd_valid = 1'b0; #1;
    chkw("cl_dac_data", dac_data, 14'h1000);
    chk1("cl_hit_set", clamp_hit, 1'b1);
    repeat (20) @(negedge clk);
    #1;
    chk1("cl_hit_sticky", clamp_hit, 1'b1);
    @(negedge clk); rst = 1'b1; #1;
    chk1("cl_hit_rst", clamp_hit, 1'b0);
    @(negedge clk); rst = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dac_update_scheduler.md
Name: dac_update_scheduler

Overview:
- Owns the single DAC channel in the SPGD datapath.
- Arbitrates DAC code updates between two requesters: the SPGD perturbation engine and the host/manual register path.
- Converts offset-binary codes to the DAC's two's-complement format, registers the output, and enforces a programmable settle interval.
- Pulses settle_done when the interval ends, so the SPGD engine samples the detector only after the mirror/modulator has settled.

Parameters:
- WIRE_WIDTH, 14: DAC code width in bits.
- SETTLE_CYCLES, 16: clock cycles held after each update before the next grant. Legal range is 1 to 65535.
- CNT_WIDTH, 16: settle counter width. Must satisfy 2^CNT_WIDTH > SETTLE_CYCLES.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- spgd_valid  in  1  SPGD engine has a code pending.
- spgd_ready  out  1  SPGD code accepted this cycle.
- spgd_code  in  WIRE_WIDTH  SPGD requested code.
- host_valid  in  1  host has a code pending.
- host_ready  out  1  host code accepted this cycle.
- host_code  in  WIRE_WIDTH  host requested code.
- fmt_offset_bin  in  1  1 = input codes are offset binary, convert them; 0 = pass through unchanged.
- dac_data  out  WIRE_WIDTH  registered code driven to the DAC.
- dac_we  out  1  one-cycle pulse in the cycle dac_data changes.
- busy  out  1  high from acceptance until the end of settle.
- settle_done  out  1  one-cycle pulse when settle completes.
- last_src  out  1  source of the current dac_data: 0 = SPGD, 1 = host.

Behaviour:
- Reset values: dac_data=0 (midscale in two's complement), dac_we=0, busy=0, settle_done=0, last_src=0. The round-robin pointer resets to favour the host; the FSM resets to IDLE.
- Reset mid-operation: all state returns to the reset values immediately. Any pending settle is abandoned and no settle_done is emitted.
- FSM states: IDLE, LOAD, SETTLE.
- IDLE:
  - The grant is computed combinationally from the valids and the round-robin pointer.
  - If exactly one valid is high, that requester is granted.
  - If both are high, the requester not granted last time wins.
  - The granted requester's ready is high in that same cycle; ready is never high outside IDLE.
  - On handshake (valid & ready), the code and source are captured and the FSM goes to LOAD.
  - The pointer updates on every grant.
- LOAD (one cycle):
  - dac_data <= converted code; dac_we=1; last_src updated.
  - Counter <= SETTLE_CYCLES-1; next state SETTLE.
- SETTLE:
  - The counter decrements each cycle.
  - When it reaches 0, settle_done pulses for one cycle and the FSM returns to IDLE in the same cycle the pulse is high.
- Timing: busy is high in LOAD and SETTLE. An accept at cycle N gives dac_we at N+1, settle_done at N+1+SETTLE_CYCLES, and the next possible accept at N+2+SETTLE_CYCLES.
- Conversion, applied in LOAD:
  - If fmt_offset_bin=1: out = {~code[MSB], code[MSB-1:0]}. So 0x2000 maps to 0x0000, 0x3FFF to 0x1FFF, and 0x0000 to 0x2000.
  - If fmt_offset_bin=0: out = code.
  - fmt_offset_bin is sampled in LOAD only. A change during SETTLE does not alter dac_data.
- Requesters may drop valid without a handshake; no state is retained for them. Codes are not required to be held after the handshake.
- dac_data holds its value indefinitely between updates.

Optional Feature:
- Macro: DAC_SCHED_CLAMP_EN.
- When defined:
  - Add inputs clamp_min and clamp_max (WIRE_WIDTH each, offset-binary, unsigned) and output clamp_hit (1 bit, sticky, cleared only by rst).
  - In LOAD, the code is saturated to [clamp_min, clamp_max] before conversion. If saturation occurred, clamp_hit is set.
  - If clamp_min > clamp_max, the code is forced to clamp_min.
  - Comparison uses the unsigned value regardless of fmt_offset_bin.
- When undefined: these ports do not exist and codes pass to conversion unmodified.

Test Plan:
- Reset then idle → dac_data=0x0000, busy=0, both readies low, no dac_we over 50 cycles.
- spgd_code=0x3FFF, fmt_offset_bin=1, spgd_valid for one cycle at N → spgd_ready at N, dac_data=0x1FFF and dac_we at N+1, last_src=0, settle_done exactly at N+17 (SETTLE_CYCLES=16).
- Both valids held high continuously with host_code=0x0100 and spgd_code=0x0200, fmt=0 → grants alternate host, SPGD, host…, dac_data alternates 0x0100/0x0200, accepts spaced 18 cycles apart.
- Host request during SETTLE → host_ready stays low until IDLE; accepted the cycle after settle_done, with no lost or duplicated update.
- rst asserted in SETTLE 5 cycles after dac_we → outputs at reset values immediately, no settle_done; a fresh request after release completes normally.
- With DAC_SCHED_CLAMP_EN, clamp_min=0x1000, clamp_max=0x3000, spgd_code=0x3FF0, fmt=1 → dac_data=0x1000 and clamp_hit=1, held until rst.
